// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Final pipeline stage. Retires or traps the instruction arriving from the
// memory stage. It drives the register-file write port and the CSR unit's
// write port and event strobes. It redirects fetch after traps and MRETs, and
// implements WFI as a two-state RUN/WFI sleep FSM.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   valid_in ... wfi_in   instruction presented by the memory stage
//   eip, tip, sip         gated pending interrupts from the CSR unit
//   trap_vector           trap handler base from the CSR unit
//   mret_vector           MRET return address from the CSR unit
//   reg_write_*           register-file write port (registered)
//   csr_write_*           CSR write port (registered)
//   retired, traped, mret one-cycle event strobes (registered)
//   ecp, trap_cause,
//   interupt              trap details. Cause and interrupt flag hold between
//                         traps.
//   redirect, redirect_pc fetch restart, one cycle after a trap or MRET
//   flush                 kill younger in-flight instructions (same cycle as
//                         redirect)
//   stall                 hold upstream stages while sleeping in WFI
// -----------------------------------------------------------------------------
module writeback_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] next_pc_in,
  input  logic [4:0]  rd_address_in,
  input  logic [31:0] rd_data_in,
  input  logic        csr_write_in,
  input  logic [11:0] csr_address_in,
  input  logic [31:0] csr_data_in,
  input  logic        exception_in,
  input  logic [3:0]  exception_cause_in,
  input  logic        mret_in,
  input  logic        wfi_in,
  input  logic        eip,
  input  logic        tip,
  input  logic        sip,
  input  logic [31:0] trap_vector,
  input  logic [31:0] mret_vector,
  output logic        reg_write_enable,
  output logic [4:0]  reg_write_address,
  output logic [31:0] reg_write_data,
  output logic        csr_write_enable,
  output logic [11:0] csr_write_address,
  output logic [31:0] csr_write_data,
  output logic        retired,
  output logic        traped,
  output logic        mret,
  output logic [31:0] ecp,
  output logic [3:0]  trap_cause,
  output logic        interupt,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        stall
);

  typedef enum logic {
    S_RUN,
    S_WFI
  } state_t;

  state_t      state;
  logic [31:0] wfi_pc;          // successor PC of the sleeping WFI, used as ecp on wake
  logic        redirect_q;      // a trap or MRET was committed last cycle
  logic        redirect_trap_q; // that event was a trap (otherwise an MRET)

  logic       irq_any;
  logic [3:0] irq_cause;

  // RESET_VECTOR and the low bits of trap_vector do not affect this stage.
  logic unused_ok;
  assign unused_ok = ^{RESET_VECTOR, trap_vector[1:0]};

  // External interrupt outranks software, which outranks timer.
  assign irq_any   = eip | tip | sip;
  assign irq_cause = eip ? 4'd11 : (sip ? 4'd3 : 4'd7);

  // The CSR values are stable for the whole redirect cycle, so they are used
  // directly rather than captured at trap time.
  assign redirect    = redirect_q;
  assign flush       = redirect_q;
  assign redirect_pc = !redirect_q     ? 32'h0 :
                       redirect_trap_q ? {trap_vector[31:2], 2'b00} :
                                         mret_vector;
  assign stall       = (state == S_WFI);

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_RUN;
      wfi_pc            <= 32'h0;
      redirect_q        <= 1'b0;
      redirect_trap_q   <= 1'b0;
      reg_write_enable  <= 1'b0;
      reg_write_address <= 5'd0;
      reg_write_data    <= 32'h0;
      csr_write_enable  <= 1'b0;
      csr_write_address <= 12'h0;
      csr_write_data    <= 32'h0;
      retired           <= 1'b0;
      traped            <= 1'b0;
      mret              <= 1'b0;
      ecp               <= 32'h0;
      trap_cause        <= 4'd0;
      interupt          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let the redirect registers below read
      // last cycle's traped/mret even though those are reassigned here too.
      // Strobes default low so that each one lasts exactly one cycle.
      reg_write_enable <= 1'b0;
      csr_write_enable <= 1'b0;
      retired          <= 1'b0;
      traped           <= 1'b0;
      mret             <= 1'b0;
      redirect_q       <= traped | mret;
      redirect_trap_q  <= traped;

      unique case (state)
        S_RUN: begin
          // An instruction arriving during a redirect is younger than the
          // trap or MRET and is squashed.
          if (valid_in && !redirect_q) begin
            if (irq_any) begin
              traped     <= 1'b1;
              interupt   <= 1'b1;
              trap_cause <= irq_cause;
              ecp        <= pc_in;
            end else if (exception_in) begin
              traped     <= 1'b1;
              interupt   <= 1'b0;
              trap_cause <= exception_cause_in;
              ecp        <= pc_in;
            end else if (mret_in) begin
              mret    <= 1'b1;
              retired <= 1'b1;
            end else if (wfi_in) begin
              retired <= 1'b1;
              wfi_pc  <= next_pc_in;
              state   <= S_WFI;
            end else begin
              retired           <= 1'b1;
              reg_write_enable  <= (rd_address_in != 5'd0);
              reg_write_address <= rd_address_in;
              reg_write_data    <= rd_data_in;
              csr_write_enable  <= csr_write_in;
              csr_write_address <= csr_address_in;
              csr_write_data    <= csr_data_in;
            end
          end
        end

        S_WFI: begin
          // Sleeping: instructions are ignored. An interrupt wakes the core
          // and resumes after the WFI.
          if (irq_any) begin
            traped     <= 1'b1;
            interupt   <= 1'b1;
            trap_cause <= irq_cause;
            ecp        <= wfi_pc;
            state      <= S_RUN;
          end
        end

        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//
// Directed stimulus for writeback_stage. A behavioural model predicts the
// registered outputs from the retire/trap rules, and one process compares the
// DUT against that model on every cycle. Literal expectations at key points
// pin both the DUT and the model.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] pc_in, next_pc_in, rd_data_in, csr_data_in;
  logic [4:0]  rd_address_in;
  logic        csr_write_in;
  logic [11:0] csr_address_in;
  logic        exception_in;
  logic [3:0]  exception_cause_in;
  logic        mret_in, wfi_in, eip, tip, sip;
  logic [31:0] trap_vector, mret_vector;

  logic        reg_write_enable;
  logic [4:0]  reg_write_address;
  logic [31:0] reg_write_data;
  logic        csr_write_enable;
  logic [11:0] csr_write_address;
  logic [31:0] csr_write_data;
  logic        retired, traped, mret;
  logic [31:0] ecp;
  logic [3:0]  trap_cause;
  logic        interupt, redirect, flush, stall;
  logic [31:0] redirect_pc;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in),
    .next_pc_in(next_pc_in), .rd_address_in(rd_address_in),
    .rd_data_in(rd_data_in), .csr_write_in(csr_write_in),
    .csr_address_in(csr_address_in), .csr_data_in(csr_data_in),
    .exception_in(exception_in), .exception_cause_in(exception_cause_in),
    .mret_in(mret_in), .wfi_in(wfi_in), .eip(eip), .tip(tip), .sip(sip),
    .trap_vector(trap_vector), .mret_vector(mret_vector),
    .reg_write_enable(reg_write_enable), .reg_write_address(reg_write_address),
    .reg_write_data(reg_write_data), .csr_write_enable(csr_write_enable),
    .csr_write_address(csr_write_address), .csr_write_data(csr_write_data),
    .retired(retired), .traped(traped), .mret(mret), .ecp(ecp),
    .trap_cause(trap_cause), .interupt(interupt), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush), .stall(stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    logic        rwe;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        cwe;
    logic [11:0] caddr;
    logic [31:0] cdata;
    logic        ret, trp, mr, intr;
    logic [31:0] epc;
    logic [3:0]  cause;
  } out_t;

  typedef enum int { NONE, BY_TRAP, BY_MRET } redir_t;

  out_t        m;            // expected registered outputs
  logic        m_sleep;      // core is asleep in WFI
  logic [31:0] m_wake_pc;
  redir_t      m_redir;      // what, if anything, is redirecting this cycle
  logic        m_ready = 1'b0;

  always @(posedge clk) begin : model
    out_t        n;
    logic        sleep_n;
    logic [31:0] wake_n;
    logic [3:0]  icause;
    n       = m;
    sleep_n = m_sleep;
    wake_n  = m_wake_pc;
    icause  = eip ? 4'd11 : sip ? 4'd3 : 4'd7;
    n.rwe = 0; n.cwe = 0; n.ret = 0; n.trp = 0; n.mr = 0;
    if (reset) begin
      n = '{default: '0};
      sleep_n = 0;
      wake_n  = 0;
    end else if (m_sleep) begin
      if (eip || tip || sip) begin
        n.trp = 1; n.intr = 1; n.cause = icause; n.epc = m_wake_pc;
        sleep_n = 0;
      end
    end else if (valid_in && m_redir == NONE) begin
      if (eip || tip || sip) begin
        n.trp = 1; n.intr = 1; n.cause = icause; n.epc = pc_in;
      end else if (exception_in) begin
        n.trp = 1; n.intr = 0; n.cause = exception_cause_in; n.epc = pc_in;
      end else if (mret_in) begin
        n.mr = 1; n.ret = 1;
      end else if (wfi_in) begin
        n.ret = 1; sleep_n = 1; wake_n = next_pc_in;
      end else begin
        n.ret = 1;
        n.rwe = (rd_address_in != 0); n.raddr = rd_address_in; n.rdata = rd_data_in;
        n.cwe = csr_write_in; n.caddr = csr_address_in; n.cdata = csr_data_in;
      end
    end
    m_redir   <= reset ? NONE : m.trp ? BY_TRAP : m.mr ? BY_MRET : NONE;
    m         <= n;
    m_sleep   <= sleep_n;
    m_wake_pc <= wake_n;
    m_ready   <= 1'b1;
  end

  // --------------------------------------------------------------- compare
  always @(negedge clk) begin
    if (m_ready) begin
      check("retired", retired, m.ret);
      check("traped", traped, m.trp);
      check("mret", mret, m.mr);
      check("trap_cause", trap_cause, m.cause);
      check("interupt", interupt, m.intr);
      check("reg_we", reg_write_enable, m.rwe);
      check("csr_we", csr_write_enable, m.cwe);
      check("redirect", redirect, m_redir != NONE);
      check("flush", flush, m_redir != NONE);
      check("stall", stall, m_sleep);
      if (m.rwe) begin
        check("reg_addr", reg_write_address, m.raddr);
        check("reg_data", reg_write_data, m.rdata);
      end
      if (m.cwe) begin
        check("csr_addr", csr_write_address, m.caddr);
        check("csr_data", csr_write_data, m.cdata);
      end
      if (m.trp) check("ecp", ecp, m.epc);
      if (m_redir != NONE)
        check("redirect_pc", redirect_pc,
              m_redir == BY_TRAP ? {trap_vector[31:2], 2'b00} : mret_vector);
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic idle();
    valid_in = 0; exception_in = 0; mret_in = 0; wfi_in = 0; csr_write_in = 0;
    eip = 0; tip = 0; sip = 0;
    pc_in = 0; next_pc_in = 0; rd_address_in = 0; rd_data_in = 0;
    csr_address_in = 0; csr_data_in = 0; exception_cause_in = 0;
  endtask

  // Let one clock edge sample the inputs; outputs are settled on return.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic instr(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
    valid_in = 1; pc_in = pc; next_pc_in = pc + 4; rd_address_in = rd; rd_data_in = data;
  endtask

  initial begin
    reset = 1;
    trap_vector = 32'h0; mret_vector = 32'h0;
    idle();
    repeat (3) cyc();
    check("lit_reset_retired", retired, 0);
    check("lit_reset_stall", stall, 0);
    check("lit_reset_redirect", redirect, 0);
    check("lit_reset_cause", trap_cause, 0);
    reset = 0;
    cyc();

    // plain register write
    instr(32'h100, 5'd5, 32'hDEAD);
    cyc();
    check("lit_add_rwe", reg_write_enable, 1);
    check("lit_add_raddr", reg_write_address, 5);
    check("lit_add_rdata", reg_write_data, 32'hDEAD);
    check("lit_add_retired", retired, 1);
    idle();
    cyc();
    check("lit_add_rwe_low", reg_write_enable, 0);
    check("lit_add_ret_low", retired, 0);

    // rd=0 with a CSR write
    instr(32'h104, 5'd0, 32'h5555);
    csr_write_in = 1; csr_address_in = 12'h340; csr_data_in = 32'h1234;
    cyc();
    check("lit_csr_rwe", reg_write_enable, 0);
    check("lit_csr_cwe", csr_write_enable, 1);
    check("lit_csr_addr", csr_write_address, 12'h340);
    check("lit_csr_data", csr_write_data, 32'h1234);
    check("lit_csr_retired", retired, 1);
    idle();

    // synchronous exception, then a squashed instruction in the redirect cycle
    trap_vector = 32'h8000_0003;
    instr(32'h200, 5'd3, 32'h33);
    exception_in = 1; exception_cause_in = 4'd2;
    cyc();
    check("lit_exc_traped", traped, 1);
    check("lit_exc_ecp", ecp, 32'h200);
    check("lit_exc_cause", trap_cause, 2);
    check("lit_exc_intr", interupt, 0);
    check("lit_exc_retired", retired, 0);
    check("lit_exc_rwe", reg_write_enable, 0);
    idle();
    cyc();
    check("lit_exc_redirect", redirect, 1);
    check("lit_exc_flush", flush, 1);
    check("lit_exc_rpc", redirect_pc, 32'h8000_0000);
    instr(32'h204, 5'd7, 32'h77);
    cyc();
    check("lit_squash_rwe", reg_write_enable, 0);
    check("lit_squash_ret", retired, 0);
    check("lit_squash_redirect", redirect, 0);
    idle();
    cyc();

    // interrupts taken on a valid instruction
    instr(32'h300, 5'd9, 32'h99);
    eip = 1; tip = 1; sip = 1;
    cyc();
    check("lit_irq_cause11", trap_cause, 11);
    check("lit_irq_intr", interupt, 1);
    check("lit_irq_ecp", ecp, 32'h300);
    check("lit_irq_rwe", reg_write_enable, 0);
    idle();
    repeat (2) cyc();
    instr(32'h310, 5'd9, 32'h99);
    tip = 1; sip = 1;
    cyc();
    check("lit_irq_cause3", trap_cause, 3);
    idle();
    repeat (2) cyc();
    // cause and interrupt flag hold after the trap
    instr(32'h320, 5'd1, 32'h11);
    cyc();
    check("lit_hold_cause", trap_cause, 3);
    check("lit_hold_intr", interupt, 1);
    idle();
    // interrupt pending with no valid instruction waits
    tip = 1;
    repeat (2) cyc();
    check("lit_irq_wait", traped, 0);
    idle();

    // MRET
    mret_vector = 32'h444;
    instr(32'h330, 5'd0, 32'h0);
    mret_in = 1;
    cyc();
    check("lit_mret", mret, 1);
    check("lit_mret_retired", retired, 1);
    idle();
    cyc();
    check("lit_mret_redirect", redirect, 1);
    check("lit_mret_rpc", redirect_pc, 32'h444);
    cyc();

    // WFI, sleep ten cycles with instructions ignored, wake on timer
    instr(32'h500, 5'd0, 32'h0);
    next_pc_in = 32'h504; wfi_in = 1;
    cyc();
    check("lit_wfi_retired", retired, 1);
    idle();
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) instr(32'h600 + i * 4, 5'd4, 32'hF00 + i);
      cyc();
      check("lit_wfi_stall", stall, 1);
      check("lit_wfi_ignored", retired, 0);
      idle();
    end
    tip = 1;
    cyc();
    check("lit_wake_traped", traped, 1);
    check("lit_wake_cause", trap_cause, 7);
    check("lit_wake_ecp", ecp, 32'h504);
    check("lit_wake_stall", stall, 0);
    idle();
    repeat (3) cyc();

    // WFI again, reset while asleep
    instr(32'h700, 5'd0, 32'h0);
    next_pc_in = 32'h704; wfi_in = 1;
    cyc();
    idle();
    repeat (4) cyc();
    check("lit_wfi2_stall", stall, 1);
    reset = 1;
    cyc();
    check("lit_rst_stall", stall, 0);
    check("lit_rst_retired", retired, 0);
    check("lit_rst_cause", trap_cause, 0);
    check("lit_rst_intr", interupt, 0);
    reset = 0;
    cyc();
    instr(32'h800, 5'd6, 32'hCAFE);
    cyc();
    check("lit_post_rwe", reg_write_enable, 1);
    check("lit_post_data", reg_write_data, 32'hCAFE);
    idle();
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
